// File: rtl/fmc150_spi_pkg.sv
// fmc150_spi_pkg
// Shared declarations for the FMC150 SPI bus arbiter: the transfer state
// encoding, the width of the per-requester length field and the chip-select
// index assigned to each FMC150 device.
// Ports: none (package).
package fmc150_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_HOLD,
    ST_DONE
  } spi_state_t;

  localparam int c_len_width = 6;

  localparam int c_cs_adc  = 0;
  localparam int c_cs_cdce = 1;
  localparam int c_cs_dac  = 2;
  localparam int c_cs_mon  = 3;

endpackage

// File: rtl/fmc150_spi_rr_arbiter.sv
// fmc150_spi_rr_arbiter
// Combinational round-robin pick: returns the first set request at or after
// the pointer position, wrapping around, as a one-hot vector.
// Ports:
//   req_i  per-requester request level
//   ptr_i  index where the search starts (highest priority this round)
//   gnt_o  one-hot pick, all zero when no request is set
module fmc150_spi_rr_arbiter #(
  parameter int g_num_req   = 4,
  parameter int g_ptr_width = 2
) (
  input  logic [g_num_req-1:0]   req_i,
  input  logic [g_ptr_width-1:0] ptr_i,
  output logic [g_num_req-1:0]   gnt_o
);

  int   idx;
  logic found;

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < g_num_req; i++) begin
      idx = (int'(ptr_i) + i) % g_num_req;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmc150_spi_arbiter.sv
// fmc150_spi_arbiter
// Shares the FMC150 SPI bus (common SCLK/SDATA, per-device CS_n and SDO)
// between the ADC, CDCE, DAC and monitor configuration requesters. A
// round-robin pick grants one requester, its frame is shifted out MSB-first,
// SDO is captured LSB-justified and a one-cycle ack ends the transfer.
//
// Optional build macro: FMC150_SPI_RDBACK_EN
//   defined   - the granted device's SDO is captured into rdata_o
//   undefined - spi_sdo_i is ignored and rdata_o is constantly zero
//
// Ports:
//   clk_sys_i    system clock, rising edge
//   rst_i        synchronous reset, active-high
//   req_i        per-requester request level
//   req_data_i   per-requester frame, MSB-justified, g_data_width each
//   req_len_i    per-requester frame length in bits, 6 bits each
//   ack_o        one-cycle completion pulse to the granted requester
//   grant_o      one-hot current grant, zero when idle
//   rdata_o      captured SDO bits, LSB-justified, valid with ack_o
//   busy_o       high from grant through DONE
//   spi_sclk_o   shared SPI clock, idles low
//   spi_sdata_o  shared SPI MOSI
//   spi_cs_n_o   per-device chip select, active-low
//   spi_sdo_i    per-device MISO
module fmc150_spi_arbiter
  import fmc150_spi_pkg::*;
#(
  parameter int g_num_req    = 4,
  parameter int g_data_width = 32,
  parameter int g_clk_div    = 4
) (
  input  logic                                 clk_sys_i,
  input  logic                                 rst_i,
  input  logic [g_num_req-1:0]                 req_i,
  input  logic [g_num_req*g_data_width-1:0]    req_data_i,
  input  logic [g_num_req*c_len_width-1:0]     req_len_i,
  output logic [g_num_req-1:0]                 ack_o,
  output logic [g_num_req-1:0]                 grant_o,
  output logic [g_data_width-1:0]              rdata_o,
  output logic                                 busy_o,
  output logic                                 spi_sclk_o,
  output logic                                 spi_sdata_o,
  output logic [g_num_req-1:0]                 spi_cs_n_o,
  input  logic [g_num_req-1:0]                 spi_sdo_i
);

  localparam int c_ptr_w = (g_num_req > 1) ? $clog2(g_num_req) : 1;
  localparam int c_div_w = (g_clk_div > 1) ? $clog2(g_clk_div) : 1;
  localparam logic [c_div_w-1:0]     c_div_last = c_div_w'(g_clk_div - 1);
  localparam logic [c_len_width-1:0] c_len_max  = c_len_width'(g_data_width);
  localparam logic [c_ptr_w-1:0]     c_ptr_last = c_ptr_w'(g_num_req - 1);

  spi_state_t state_q, state_d;

  logic [g_num_req-1:0]    pick;
  int                      pick_idx;
  logic [c_len_width-1:0]  len_sel;
  logic [c_len_width-1:0]  len_clamped;
  logic [g_data_width-1:0] data_sel;

  logic [c_ptr_w-1:0]      ptr_q;
  logic [g_num_req-1:0]    grant_q;
  logic [c_ptr_w-1:0]      grant_idx_q;
  logic [g_data_width-1:0] shreg_q;
  logic [c_len_width-1:0]  bits_left_q;
  logic [c_div_w-1:0]      div_q;
  logic                    phase_end;
  logic                    start;

  fmc150_spi_rr_arbiter #(
    .g_num_req  (g_num_req),
    .g_ptr_width(c_ptr_w)
  ) u_rr_arbiter (
    .req_i(req_i),
    .ptr_i(ptr_q),
    .gnt_o(pick)
  );

  // Turn the one-hot pick into an index so the winner's frame can be muxed.
  always_comb begin
    pick_idx = 0;
    for (int i = 0; i < g_num_req; i++) begin
      if (pick[i]) pick_idx = i;
    end
  end

  // Winner's frame and length; oversize lengths are clamped to the register.
  always_comb begin
    len_sel     = req_len_i[pick_idx*c_len_width +: c_len_width];
    data_sel    = req_data_i[pick_idx*g_data_width +: g_data_width];
    len_clamped = (len_sel > c_len_max) ? c_len_max : len_sel;
  end

  assign start     = (state_q == ST_IDLE) && (|req_i);
  assign phase_end = (div_q == c_div_last);

  // State register.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state. Every timed phase lasts g_clk_div cycles; the first LO phase
  // after SETUP has no falling edge, so SCLK is low for two phases before the
  // first rising edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = (len_clamped == '0) ? ST_DONE : ST_SETUP;
      ST_SETUP:    if (phase_end) state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (phase_end) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (phase_end) state_d = (bits_left_q == c_len_width'(1)) ? ST_HOLD : ST_SHIFT_LO;
      ST_HOLD:     if (phase_end) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register and the latched grant.
  always_comb begin
    ack_o       = '0;
    grant_o     = '0;
    busy_o      = 1'b0;
    spi_cs_n_o  = '1;
    spi_sclk_o  = 1'b0;
    spi_sdata_o = 1'b0;
    case (state_q)
      ST_SETUP, ST_SHIFT_LO, ST_SHIFT_HI: begin
        grant_o     = grant_q;
        busy_o      = 1'b1;
        spi_cs_n_o  = ~grant_q;
        spi_sclk_o  = (state_q == ST_SHIFT_HI);
        spi_sdata_o = shreg_q[g_data_width-1];
      end
      ST_HOLD: begin
        grant_o    = grant_q;
        busy_o     = 1'b1;
        spi_cs_n_o = ~grant_q;
      end
      ST_DONE: begin
        grant_o = grant_q;
        busy_o  = 1'b1;
        ack_o   = grant_q;
      end
      default: ;
    endcase
  end

  // Phase timer: restarts at every phase boundary, parked at zero when idle.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else if (state_q == ST_SETUP || state_q == ST_SHIFT_LO ||
                 state_q == ST_SHIFT_HI || state_q == ST_HOLD) begin
      div_q <= phase_end ? '0 : div_q + c_div_w'(1);
    end else begin
      div_q <= '0;
    end
  end

  // Grant/frame latch, shift register, bit counter and round-robin pointer.
  // The shift happens at the HI->LO boundary so the next bit appears with
  // the falling SCLK edge.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      shreg_q     <= '0;
      bits_left_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            grant_q     <= pick;
            grant_idx_q <= c_ptr_w'(pick_idx);
            shreg_q     <= data_sel;
            bits_left_q <= len_clamped;
          end
        end
        ST_SHIFT_HI: begin
          if (phase_end) begin
            bits_left_q <= bits_left_q - c_len_width'(1);
            shreg_q     <= {shreg_q[g_data_width-2:0], 1'b0};
          end
        end
        ST_DONE: begin
          grant_q <= '0;
          ptr_q   <= (grant_idx_q == c_ptr_last) ? '0 : grant_idx_q + c_ptr_w'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef FMC150_SPI_RDBACK_EN
  logic [g_data_width-1:0] rdata_q;

  // SDO capture: one sample per bit, taken in the first cycle SCLK is high,
  // shifted in at the LSB so the word ends up LSB-justified.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (start) begin
      rdata_q <= '0;
    end else if (state_q == ST_SHIFT_HI && div_q == '0) begin
      rdata_q <= {rdata_q[g_data_width-2:0], spi_sdo_i[grant_idx_q]};
    end
  end

  assign rdata_o = rdata_q;
`else
  logic unused_sdo;
  assign unused_sdo = ^spi_sdo_i;
  assign rdata_o    = '0;
`endif

endmodule
